fetch_pair_queue: RTL and testbench
===================================

# fetch_pair_queue

Dual-issue instruction queue between instruction memory and the Decode stage. Accepts up to two fetched instructions (with PC) per cycle, buffers them in a circular store, and presents the two oldest entries to the Decode pipeline register with per-slot valid bits. Decode consumes 0, 1 or 2 entries per cycle. A redirect flush empties the queue in one cycle.

## Interface
Parameters:
- WIDTH, 32, data/PC width
- DEPTH, 8, entry count; power of two, ≥4

Ports:
- Single clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- flush  in  1  discard all entries (branch/jump redirect)
- enq_valid  in  2  per-slot fetch valid; bit1 only legal with bit0
- enq_pc[1:0]  in  WIDTH each  PC of fetched instructions
- enq_instr[1:0]  in  WIDTH each  fetched instruction words
- enq_ready  out  1  queue can take two entries this cycle
- deq_valid  out  2  slot0 = oldest entry, slot1 = second-oldest
- deq_pc[1:0]  out  WIDTH each  PC per slot
- deq_instr[1:0]  out  WIDTH each  instruction per slot
- deq_normal[1:0]  out  WIDTH each  deq_pc + 4 per slot
- deq_accept  in  2  Decode consumes slots; thermometer (00/01/11)
- count  out  $clog2(DEPTH)+1  current occupancy
- ovf_err  out  1  sticky: enqueue attempted while enq_ready=0

## Operation
- Storage: DEPTH entries of {pc, instr}; wr_ptr, rd_ptr, count; pointers wrap modulo DEPTH.
- enq_ready = (count ≤ DEPTH-2); depends on registered count only, never on deq_accept.
- n_enq = enq_ready ? (enq_valid[0] + (enq_valid[0] & enq_valid[1])) : 0; enq_valid=2'b10 → n_enq=0.
- Entries written at wr_ptr, wr_ptr+1 (mod DEPTH); wr_ptr += n_enq.
- deq_valid[0] = count≥1; deq_valid[1] = count≥2.
- Slot i reads entry rd_ptr+i (mod DEPTH). Invalid slot: deq_instr = 32'h00000013 (NOP), deq_pc = 0, deq_normal = 4.
- n_deq = (deq_accept[0] & deq_valid[0]) + (deq_accept[0] & deq_accept[1] & deq_valid[1]); accept bits on invalid slots and deq_accept=2'b10 ignored.
- count_next = count + n_enq − n_deq; simultaneous enq and deq both take effect.
- ovf_err set when enq_valid[0]=1 and enq_ready=0; that fetch is dropped; cleared only by rst or flush.
- flush: highest priority; next cycle count=0, rd_ptr=wr_ptr=0, ovf_err=0; same-cycle enq and deq are discarded.
- deq_normal computed with WIDTH-bit wrap (0xFFFFFFFC+4 = 0).

## Timing
- Reset (async, active-high): count=0, pointers=0, ovf_err=0, deq_valid=00, enq_ready=1, deq outputs at NOP/0/4. Storage contents not reset.
- Enqueue at edge N → entry visible on deq_* in cycle after edge N (1-cycle latency, default build).
- Dequeue at edge N → slot shifts (old slot1 becomes slot0) in cycle after edge N.
- enq_ready, deq_valid, count: functions of registered state only.
- Reset asserted mid-operation: queue empties immediately, independent of clk.
- Wrap-around: two-entry enq/deq straddling index DEPTH-1→0 is single-cycle, ordering preserved.

## Configuration
- FETCHQ_BYPASS_EN defined: when count=0 and flush=0, enq slots drive deq_* combinationally in the same cycle (deq_valid = enq_valid masked to legal patterns); accepted bypassed entries are not stored, the remainder is written. 0-cycle latency on empty queue.
- Undefined: no bypass; strict 1-cycle latency; no combinational path enq_* → deq_*.

## Test plan
- Reset, then enq 2 instrs (PC 0x0, 0x4), deq_accept=00 → next cycle deq_valid=11, deq_normal = {0x8, 0x4}, count=2.
- Fill to DEPTH=8 with pairs, no accept → enq_ready=0 at count=7 and 8; extra enq sets ovf_err=1, count stays 8.
- Steady state: enq 2 and accept 11 every cycle across pointer wrap → count constant, PCs emerge in order, no gaps.
- count=3, deq_accept=01 with enq 2 → next cycle count=4, old second entry now in slot0.
- count=5, ovf_err=1, flush=1 with enq_valid=11 → next cycle count=0, deq_valid=00, ovf_err=0, deq_instr=0x00000013.
- With FETCHQ_BYPASS_EN, empty queue, enq PC 0x100/0x104, accept 01 → same cycle deq_pc[0]=0x100; next cycle count=1, slot0 PC 0x104.

Source files
------------

// File: rtl/fetch_pair_queue.sv
// fetch_pair_queue: dual-issue instruction queue between fetch and Decode, two in / two out per cycle.
// Optional same-cycle bypass on an empty queue is enabled by defining FETCHQ_BYPASS_EN.
module fetch_pair_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [1:0]              enq_valid,
    input  logic [1:0][WIDTH-1:0]   enq_pc,
    input  logic [1:0][WIDTH-1:0]   enq_instr,
    output logic                    enq_ready,
    output logic [1:0]              deq_valid,
    output logic [1:0][WIDTH-1:0]   deq_pc,
    output logic [1:0][WIDTH-1:0]   deq_instr,
    output logic [1:0][WIDTH-1:0]   deq_normal,
    input  logic [1:0]              deq_accept,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ovf_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013);

    logic [WIDTH-1:0] mem_pc    [DEPTH];
    logic [WIDTH-1:0] mem_instr [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          ovf_reg;

    logic [1:0]    n_enq;
    logic [1:0]    n_deq;
    logic [1:0]    n_wr;
    logic [1:0]    n_pop;
    logic          src_sel;

`ifdef FETCHQ_BYPASS_EN
    logic          bypass;
    assign bypass = (count_reg == '0) && !flush;
`endif

    assign enq_ready = (count_reg <= CW'(DEPTH - 2));
    assign count     = count_reg;
    assign ovf_err   = ovf_reg;

    // n_wr/n_pop are what actually touches storage; bypassed entries skip it entirely.
    always_comb begin
        n_enq = 2'd0;
        if (enq_ready) begin
            n_enq = {1'b0, enq_valid[0]} + {1'b0, enq_valid[0] & enq_valid[1]};
        end
        n_deq   = {1'b0, deq_accept[0] & deq_valid[0]}
                + {1'b0, deq_accept[0] & deq_accept[1] & deq_valid[1]};
        n_wr    = n_enq;
        n_pop   = n_deq;
        src_sel = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        if (bypass) begin
            n_wr    = n_enq - n_deq;
            n_pop   = 2'd0;
            src_sel = n_deq[0];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PW'(n_wr);
            rd_ptr_reg <= rd_ptr_reg + PW'(n_pop);
            count_reg  <= count_reg + CW'(n_wr) - CW'(n_pop);
            if (enq_valid[0] && !enq_ready) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (n_wr != 2'd0) begin
                mem_pc[wr_ptr_reg]    <= enq_pc[src_sel];
                mem_instr[wr_ptr_reg] <= enq_instr[src_sel];
            end
            if (n_wr == 2'd2) begin
                mem_pc[wr_ptr_reg + PW'(1)]    <= enq_pc[1];
                mem_instr[wr_ptr_reg + PW'(1)] <= enq_instr[1];
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [PW-1:0]    rd_idx;
        logic             slot_valid;
        logic [WIDTH-1:0] slot_pc;
        logic [WIDTH-1:0] slot_instr;

        assign rd_idx = rd_ptr_reg + PW'(gi);

        always_comb begin
            slot_valid = (count_reg > CW'(gi));
            slot_pc    = mem_pc[rd_idx];
            slot_instr = mem_instr[rd_idx];
`ifdef FETCHQ_BYPASS_EN
            if (bypass) begin
                slot_valid = (gi == 0) ? enq_valid[0] : (enq_valid[0] & enq_valid[1]);
                slot_pc    = enq_pc[gi];
                slot_instr = enq_instr[gi];
            end
`endif
            if (!slot_valid) begin
                slot_pc    = '0;
                slot_instr = NOP_INSTR;
            end
        end

        assign deq_valid[gi]  = slot_valid;
        assign deq_pc[gi]     = slot_pc;
        assign deq_instr[gi]  = slot_instr;
        assign deq_normal[gi] = slot_pc + WIDTH'(4);
    end

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed bench for fetch_pair_queue: queue-level reference model checked every cycle plus literal anchors.
module tb_fetch_pair_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [1:0]        enq_valid;
    logic [1:0][31:0]  enq_pc;
    logic [1:0][31:0]  enq_instr;
    logic              enq_ready;
    logic [1:0]        deq_valid;
    logic [1:0][31:0]  deq_pc;
    logic [1:0][31:0]  deq_instr;
    logic [1:0][31:0]  deq_normal;
    logic [1:0]        deq_accept;
    logic [3:0]        count;
    logic              ovf_err;

    fetch_pair_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_instr(enq_instr),
        .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_instr(deq_instr),
        .deq_normal(deq_normal), .deq_accept(deq_accept),
        .count(count), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t mq[$];
    ent_t vis[$];
    bit   m_ovf;
    bit   m_byp;
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // What Decode must see: two oldest queued entries, or the legal fetch slots when bypassing.
    task automatic model_check();
        ent_t e;
        logic [31:0] epc, eins;
        vis.delete();
        m_byp = BYP && (mq.size() == 0) && !flush;
        if (m_byp) begin
            if (enq_valid[0]) begin
                e.pc = enq_pc[0]; e.instr = enq_instr[0]; vis.push_back(e);
            end
            if (enq_valid == 2'b11) begin
                e.pc = enq_pc[1]; e.instr = enq_instr[1]; vis.push_back(e);
            end
        end else begin
            for (int i = 0; i < 2 && i < mq.size(); i++) vis.push_back(mq[i]);
        end
        for (int i = 0; i < 2; i++) begin
            epc  = (i < vis.size()) ? vis[i].pc    : 32'h0;
            eins = (i < vis.size()) ? vis[i].instr : 32'h0000_0013;
            chk($sformatf("slot%0d_valid", i), {31'b0, deq_valid[i]}, (i < vis.size()) ? 32'd1 : 32'd0);
            chk($sformatf("slot%0d_pc", i), deq_pc[i], epc);
            chk($sformatf("slot%0d_instr", i), deq_instr[i], eins);
            chk($sformatf("slot%0d_normal", i), deq_normal[i], epc + 32'd4);
        end
        chk("count", 32'(count), 32'(mq.size()));
        chk("enq_ready", {31'b0, enq_ready}, (mq.size() <= DEPTH - 2) ? 32'd1 : 32'd0);
        chk("ovf_err", {31'b0, ovf_err}, {31'b0, m_ovf});
    endtask

    task automatic model_step();
        ent_t e;
        int   nd;
        bit   rdy;
        if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            rdy = (mq.size() <= DEPTH - 2);
            nd = 0;
            if (deq_accept[0] && vis.size() >= 1) nd = 1;
            if (deq_accept == 2'b11 && vis.size() >= 2) nd = 2;
            if (m_byp) begin
                for (int i = 0; i < vis.size(); i++) mq.push_back(vis[i]);
            end
            repeat (nd) void'(mq.pop_front());
            if (!m_byp) begin
                if (rdy) begin
                    if (enq_valid[0]) begin
                        e.pc = enq_pc[0]; e.instr = enq_instr[0]; mq.push_back(e);
                    end
                    if (enq_valid == 2'b11) begin
                        e.pc = enq_pc[1]; e.instr = enq_instr[1]; mq.push_back(e);
                    end
                end else if (enq_valid[0]) begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        #1 model_check();
        @(posedge clk);
        model_step();
        $display("cyc %0d enq_v=%b pc0=%h acc=%b flush=%b -> count %0d", cyc, enq_valid, enq_pc[0],
                 deq_accept, flush, mq.size());
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] ev, input logic [31:0] pc0, input logic [1:0] acc, input logic fl);
        enq_valid    = ev;
        enq_pc[0]    = pc0;
        enq_pc[1]    = pc0 + 32'd4;
        enq_instr[0] = mk_instr(pc0);
        enq_instr[1] = mk_instr(pc0 + 32'd4);
        deq_accept   = acc;
        flush        = fl;
    endtask

    initial begin
        rst = 1'b1;
        m_ovf = 1'b0;
        drive(2'b00, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_deq_valid", {30'b0, deq_valid}, 32'd0);
        chk("rst_enq_ready", {31'b0, enq_ready}, 32'd1);
        chk("rst_ovf", {31'b0, ovf_err}, 32'd0);
        chk("rst_instr0", deq_instr[0], 32'h0000_0013);
        chk("rst_pc0", deq_pc[0], 32'h0);
        chk("rst_normal1", deq_normal[1], 32'h4);
        rst = 1'b0;
        @(negedge clk);

        // First pair, no accept
        drive(2'b11, 32'h0, 2'b00, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("t1_valid", {30'b0, deq_valid}, 32'd3);
        chk("t1_normal0", deq_normal[0], 32'h4);
        chk("t1_normal1", deq_normal[1], 32'h8);
        chk("t1_count", 32'(count), 32'd2);
        cycle();

        // Fill towards DEPTH, including an illegal 2'b10 pattern
        drive(2'b11, 32'h8, 2'b00, 1'b0); cycle();
        drive(2'b10, 32'h100, 2'b00, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("e10_count", 32'(count), 32'd4);
        chk("e10_ovf", {31'b0, ovf_err}, 32'd0);
        drive(2'b11, 32'h10, 2'b00, 1'b0); cycle();
        drive(2'b01, 32'h18, 2'b00, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("c7_count", 32'(count), 32'd7);
        chk("c7_ready", {31'b0, enq_ready}, 32'd0);
        cycle();
        drive(2'b11, 32'h200, 2'b00, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b01, 1'b0); cycle();
        drive(2'b11, 32'h1C, 2'b00, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("c8_count", 32'(count), 32'd8);
        chk("c8_ready", {31'b0, enq_ready}, 32'd0);
        chk("c8_ovf", {31'b0, ovf_err}, 32'd1);
        cycle();
        drive(2'b11, 32'h300, 2'b00, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("ovf_count", 32'(count), 32'd8);

        // Drain to 5, then flush with a competing enqueue/dequeue
        drive(2'b00, 32'h0, 2'b11, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b01, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("c5_count", 32'(count), 32'd5);
        chk("c5_ovf", {31'b0, ovf_err}, 32'd1);
        chk("c5_pc0", deq_pc[0], 32'h10);
        drive(2'b11, 32'h400, 2'b11, 1'b1); cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_valid", {30'b0, deq_valid}, 32'd0);
        chk("fl_ovf", {31'b0, ovf_err}, 32'd0);
        chk("fl_instr0", deq_instr[0], 32'h0000_0013);
        chk("fl_normal0", deq_normal[0], 32'h4);
        cycle();

        // Steady-state two-in/two-out across several pointer wraps
        drive(2'b11, 32'h1000, 2'b00, 1'b0); cycle();
        for (int k = 0; k < 12; k++) begin
            drive(2'b11, 32'h1008 + 32'(8 * k), 2'b11, 1'b0); #1;
            chk("ss_pc0", deq_pc[0], 32'h1000 + 32'(8 * k));
            chk("ss_count", 32'(count), 32'd2);
            cycle();
        end

        // count=3, accept one while enqueuing two
        drive(2'b01, 32'h2000, 2'b00, 1'b0); cycle();
        drive(2'b11, 32'h2004, 2'b01, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("p1_count", 32'(count), 32'd4);
        chk("p1_pc0", deq_pc[0], 32'h1064);
        chk("p1_pc1", deq_pc[1], 32'h2000);
        cycle();
        drive(2'b00, 32'h0, 2'b10, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("acc10_count", 32'(count), 32'd4);
        cycle();

        // PC+4 wraps at the top of the address space
        drive(2'b11, 32'hFFFF_FFF8, 2'b11, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b11, 1'b0); cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("wrap_normal0", deq_normal[0], 32'hFFFF_FFFC);
        chk("wrap_normal1", deq_normal[1], 32'h0);
        cycle();

        // Asynchronous reset between clock edges
        drive(2'b00, 32'h0, 2'b00, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", {30'b0, deq_valid}, 32'd0);
        chk("arst_ready", {31'b0, enq_ready}, 32'd1);
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef FETCHQ_BYPASS_EN
        drive(2'b11, 32'h100, 2'b01, 1'b0); #1;
        chk("byp_pc0", deq_pc[0], 32'h100);
        chk("byp_valid", {30'b0, deq_valid}, 32'd3);
        cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("byp_count", 32'(count), 32'd1);
        chk("byp_next_pc0", deq_pc[0], 32'h104);
        cycle();
`else
        drive(2'b11, 32'h100, 2'b01, 1'b0); #1;
        chk("nobyp_valid", {30'b0, deq_valid}, 32'd0);
        cycle();
        drive(2'b00, 32'h0, 2'b00, 1'b0); #1;
        chk("nobyp_count", 32'(count), 32'd2);
        chk("nobyp_pc0", deq_pc[0], 32'h100);
        cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
